// File: rtl/badpt_pkg.sv
// Shared state type, capacity derivation and LUT word packing for the
// bad-point LUT scheduler.
package badpt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAN_LOAD,
    ST_CAP_ARM,
    ST_CAP_RUN,
    ST_COMMIT_WAIT
  } badpt_state_e;

  localparam int BADPT_NUM_DEFAULT = 128;

  // One LUT slot is kept unused, so usable capacity is one below the depth.
  function automatic int badpt_cap(input int depth);
    return depth - 1;
  endfunction

  localparam int BADPT_CAP = badpt_cap(BADPT_NUM_DEFAULT);

  function automatic logic [31:0] pack_coord(input logic [15:0] y, input logic [15:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/badpt_edge_det.sv
// Rising-edge detector; history resets high so a level already asserted
// when reset releases is not mistaken for a fresh edge.
module badpt_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_prev <= 1'b1;
    else        sig_prev <= sig;
  end

  assign rise = sig && !sig_prev;

endmodule

// File: rtl/badpoint_lut_scheduler.sv
// Owns the bad-point LUT write port: manual loads or one-frame auto capture,
// with the entry count published only at frame boundaries.
// Optional: define BADPT_ORDER_CHECK_EN to enable the manual ascending-order check.
//
// state          | meaning
// ---------------+------------------------------------------------------
// ST_IDLE        | table committed, waiting for man_start / cap_req
// ST_MAN_LOAD    | accepting manual entries until man_done
// ST_CAP_ARM     | capture requested, waiting for next frame boundary
// ST_CAP_RUN     | recording detector hits for one frame
// ST_COMMIT_WAIT | manual load finished, publish count at next boundary
module badpoint_lut_scheduler
  import badpt_pkg::*;
#(
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 10,
  parameter int BAD_POINT_NUM = 128,
  parameter int BAD_POINT_BIT = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     man_start,
  input  logic                     man_valid,
  output logic                     man_ready,
  input  logic [WIDTH_BITS-1:0]    man_x,
  input  logic [HEIGHT_BITS-1:0]   man_y,
  input  logic                     man_done,
  input  logic                     cap_req,
  input  logic                     det_valid,
  input  logic [WIDTH_BITS-1:0]    det_x,
  input  logic [HEIGHT_BITS-1:0]   det_y,
  output logic                     wen_lut,
  output logic [BAD_POINT_BIT-1:0] waddr_lut,
  output logic [31:0]              wdata_lut,
  output logic [BAD_POINT_BIT-1:0] bad_point_num,
  output logic                     busy,
  output logic                     order_err,
  output logic                     det_overflow
);

  localparam int                     CAP     = badpt_cap(BAD_POINT_NUM);
  localparam logic [BAD_POINT_BIT-1:0] CAP_CNT = BAD_POINT_BIT'(CAP);

  badpt_state_e             state;
  logic [BAD_POINT_BIT-1:0] wr_cnt;
  logic                     fs_rise;
  logic                     below_cap;
  logic                     man_accept;
  logic                     man_write;
  logic                     in_order;

  badpt_edge_det u_fs_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (frame_start),
    .rise  (fs_rise)
  );

  assign below_cap  = wr_cnt < CAP_CNT;
  assign man_ready  = (state == ST_MAN_LOAD) && below_cap;
  assign busy       = (state != ST_IDLE);
  // Entries presented together with man_done are dropped without a handshake effect.
  assign man_accept = man_ready && man_valid && !man_done;
  assign man_write  = man_accept && in_order;

`ifdef BADPT_ORDER_CHECK_EN
  logic [HEIGHT_BITS+WIDTH_BITS-1:0] prev_coord;
  logic                              order_err_q;

  // wr_cnt is zero exactly until the first entry of a load is accepted.
  assign in_order  = (wr_cnt == '0) || ({man_y, man_x} > prev_coord);
  assign order_err = order_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_coord  <= '0;
      order_err_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && man_start) order_err_q <= 1'b0;
      if (man_accept) begin
        prev_coord <= {man_y, man_x};
        if (!in_order) order_err_q <= 1'b1;
      end
    end
  end
`else
  assign in_order  = 1'b1;
  assign order_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wr_cnt        <= '0;
      wen_lut       <= 1'b0;
      waddr_lut     <= '0;
      wdata_lut     <= '0;
      bad_point_num <= '0;
      det_overflow  <= 1'b0;
    end else begin
      wen_lut <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (man_start) begin
            state         <= ST_MAN_LOAD;
            wr_cnt        <= '0;
            bad_point_num <= '0;
          end else if (cap_req) begin
            state         <= ST_CAP_ARM;
            bad_point_num <= '0;
            det_overflow  <= 1'b0;
          end
        end
        ST_MAN_LOAD: begin
          if (man_done) begin
            state <= ST_COMMIT_WAIT;
          end else if (man_write) begin
            wen_lut   <= 1'b1;
            waddr_lut <= wr_cnt;
            wdata_lut <= pack_coord(16'(man_y), 16'(man_x));
            wr_cnt    <= wr_cnt + BAD_POINT_BIT'(1);
          end
        end
        ST_CAP_ARM: begin
          if (fs_rise) begin
            state  <= ST_CAP_RUN;
            wr_cnt <= '0;
          end
        end
        ST_CAP_RUN: begin
          // The boundary cycle closes the frame; a hit there belongs to the next frame.
          if (fs_rise) begin
            state         <= ST_IDLE;
            bad_point_num <= wr_cnt;
          end else if (det_valid) begin
            if (below_cap) begin
              wen_lut   <= 1'b1;
              waddr_lut <= wr_cnt;
              wdata_lut <= pack_coord(16'(det_y), 16'(det_x));
              wr_cnt    <= wr_cnt + BAD_POINT_BIT'(1);
            end else begin
              det_overflow <= 1'b1;
            end
          end
        end
        ST_COMMIT_WAIT: begin
          if (fs_rise) begin
            state         <= ST_IDLE;
            bad_point_num <= wr_cnt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_badpoint_lut_scheduler.sv
// Scoreboard bench for badpoint_lut_scheduler: stimulus tasks predict LUT
// writes and committed counts; a negedge monitor checks every write.
`timescale 1ns/1ps
module tb_badpoint_lut_scheduler;

  localparam int WB  = 10;
  localparam int HB  = 10;
  localparam int NUM = 128;
  localparam int PB  = 7;
  localparam int CAP = NUM - 1;

`ifdef BADPT_ORDER_CHECK_EN
  localparam bit ORDER_CHK = 1'b1;
`else
  localparam bit ORDER_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b1;
  logic          man_start = 1'b0;
  logic          man_valid = 1'b0;
  logic          man_done = 1'b0;
  logic          cap_req = 1'b0;
  logic          det_valid = 1'b0;
  logic [WB-1:0] man_x = '0;
  logic [HB-1:0] man_y = '0;
  logic [WB-1:0] det_x = '0;
  logic [HB-1:0] det_y = '0;
  logic          man_ready;
  logic          wen_lut;
  logic [PB-1:0] waddr_lut;
  logic [31:0]   wdata_lut;
  logic [PB-1:0] bad_point_num;
  logic          busy;
  logic          order_err;
  logic          det_overflow;

  badpoint_lut_scheduler #(
    .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .BAD_POINT_NUM(NUM), .BAD_POINT_BIT(PB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .man_start(man_start), .man_valid(man_valid), .man_ready(man_ready),
    .man_x(man_x), .man_y(man_y), .man_done(man_done),
    .cap_req(cap_req), .det_valid(det_valid), .det_x(det_x), .det_y(det_y),
    .wen_lut(wen_lut), .waddr_lut(waddr_lut), .wdata_lut(wdata_lut),
    .bad_point_num(bad_point_num), .busy(busy),
    .order_err(order_err), .det_overflow(det_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Reference model: entries in the table, last accepted key, sticky flags.
  int  m_cnt = 0;
  int  m_last = 0;
  bit  m_has_last = 0;
  bit  m_oerr = 0;
  bit  m_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int y, input int x);
    return 32'(y * 65536 + x);
  endfunction

  always @(negedge clk) begin
    if (rst_n && wen_lut) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none", waddr_lut, wdata_lut);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(waddr_lut), 32'(e.addr));
        chk("write_data", wdata_lut, e.data);
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    chk({tag, "_wen"}, 32'(wen_lut), 0);
    chk({tag, "_waddr"}, 32'(waddr_lut), 0);
    chk({tag, "_wdata"}, wdata_lut, 0);
    chk({tag, "_bpn"}, 32'(bad_point_num), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_man_ready"}, 32'(man_ready), 0);
    chk({tag, "_order_err"}, 32'(order_err), 0);
    chk({tag, "_det_ovf"}, 32'(det_overflow), 0);
  endtask

  task automatic man_begin(input bit with_cap);
    man_start = 1'b1;
    cap_req   = with_cap;
    step();
    man_start = 1'b0;
    cap_req   = 1'b0;
    m_cnt = 0; m_has_last = 0; m_oerr = 0;
    chk("man_begin_busy", 32'(busy), 1);
    chk("man_begin_bpn", 32'(bad_point_num), 0);
    chk("man_begin_order_err", 32'(order_err), 0);
  endtask

  task automatic man_entry(input int y, input int x, input bit v);
    int key;
    man_valid   = v;
    man_y       = HB'(y);
    man_x       = WB'(x);
    frame_start = 1'($urandom % 2);
    chk("man_ready", 32'(man_ready), 32'(m_cnt < CAP));
    if (v && m_cnt < CAP) begin
      key = y * 1024 + x;
      if (ORDER_CHK && m_has_last && key <= m_last) m_oerr = 1;
      else begin
        exp_q.push_back('{m_cnt, word(y, x)});
        m_cnt++;
      end
      m_last = key;
      m_has_last = 1;
    end
    step();
    man_valid = 1'b0;
  endtask

  task automatic man_commit();
    man_done  = 1'b1;
    man_valid = 1'($urandom % 2);
    man_x     = WB'($urandom);
    man_y     = HB'($urandom);
    step();
    man_done  = 1'b0;
    man_valid = 1'b0;
    frame_start = 1'b0;
    step();
    frame_start = 1'b1;
    chk("man_bpn_before_edge", 32'(bad_point_num), 0);
    step();
    chk("man_bpn_commit", 32'(bad_point_num), 32'(m_cnt));
    chk("man_busy_after_commit", 32'(busy), 0);
    chk("man_order_err", 32'(order_err), 32'(m_oerr));
  endtask

  task automatic drive_hit(input int pct);
    det_valid = 1'(($urandom % 100) < pct);
    det_x = WB'($urandom);
    det_y = HB'($urandom);
  endtask

  task automatic cap_begin(input int arm_cycles);
    cap_req = 1'b1;
    step();
    cap_req = 1'b0;
    m_ovf = 0;
    chk("cap_busy", 32'(busy), 1);
    chk("cap_bpn_cleared", 32'(bad_point_num), 0);
    chk("cap_ovf_cleared", 32'(det_overflow), 0);
    repeat (arm_cycles) begin
      drive_hit(60);
      step();
    end
    frame_start = 1'b0;
    drive_hit(100);
    step();
    frame_start = 1'b1;
    drive_hit(100);
    step();
    frame_start = 1'b0;
    m_cnt = 0;
  endtask

  task automatic cap_hits(input int cycles, input int pct);
    repeat (cycles) begin
      drive_hit(pct);
      if (det_valid) begin
        if (m_cnt < CAP) begin
          exp_q.push_back('{m_cnt, word(int'(det_y), int'(det_x))});
          m_cnt++;
        end else m_ovf = 1;
      end
      step();
    end
  endtask

  task automatic cap_commit();
    frame_start = 1'b1;
    drive_hit(100);
    chk("cap_bpn_before_edge", 32'(bad_point_num), 0);
    step();
    det_valid = 1'b0;
    chk("cap_bpn_commit", 32'(bad_point_num), 32'(m_cnt));
    chk("cap_det_overflow", 32'(det_overflow), 32'(m_ovf));
    chk("cap_busy_after_commit", 32'(busy), 0);
  endtask

  task automatic man_random(input int n);
    int key;
    key = int'($urandom_range(0, 2000));
    man_begin(1'b0);
    for (int i = 0; i < n; i++) begin
      int k;
      if ($urandom % 8 == 0) k = int'($urandom_range(0, key));
      else begin
        key = key + int'($urandom_range(1, 300));
        k = key;
      end
      man_entry(k / 1024, k % 1024, ($urandom % 4) != 0);
    end
    man_commit();
  endtask

  initial begin
    #(5ms);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_idle_zero("in_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check_idle_zero("after_reset");

    // Capture armed while frame_start is still high from reset: hits ignored until a real edge.
    cap_begin(4);
    cap_hits(20, 70);
    cap_commit();

    // Directed ascending manual load.
    man_begin(1'b0);
    man_entry(5, 3, 1);
    man_entry(5, 9, 1);
    man_entry(20, 1, 1);
    man_commit();
    chk("directed_count", 32'(bad_point_num), 3);

    // Out-of-order second entry.
    man_begin(1'b0);
    man_entry(5, 9, 1);
    man_entry(5, 3, 1);
    man_commit();
    chk("unordered_count", 32'(bad_point_num), ORDER_CHK ? 32'd1 : 32'd2);

    // Capture overflow: 130 consecutive hits into 127 slots.
    cap_begin(2);
    cap_hits(130, 100);
    cap_commit();
    chk("overflow_count", 32'(bad_point_num), 32'(CAP));

    // man_start wins over cap_req; detector hits during a manual load are ignored.
    man_begin(1'b1);
    det_valid = 1'b1;
    repeat (3) begin
      chk("man_priority_ready", 32'(man_ready), 1);
      step();
    end
    det_valid = 1'b0;
    man_entry(1, 1, 1);
    man_entry(2, 2, 1);
    man_commit();

    // Manual load run into capacity.
    man_begin(1'b0);
    for (int i = 0; i < 135; i++) man_entry(i / 100, (i % 100) * 3 + 1, 1);
    man_commit();

    for (int r = 0; r < 6; r++) begin
      man_random(int'($urandom_range(0, 40)));
      cap_begin(int'($urandom_range(0, 5)));
      cap_hits(int'($urandom_range(0, 160)), int'($urandom_range(10, 100)));
      cap_commit();
    end

    // Reset during a capture after 10 hits.
    cap_begin(1);
    cap_hits(10, 100);
    det_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_idle_zero("mid_cap_reset");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_reset_busy", 32'(busy), 0);
    chk("post_reset_bpn", 32'(bad_point_num), 0);
    man_random(5);

    repeat (3) step();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/badpoint_lut_scheduler.md
# badpoint_lut_scheduler

- Single-clock controller that owns the write port of the manual bad-point LUT and sequences its contents. Two table sources:
  - manual mode: a software/register requester writes entries.
  - auto-capture mode: one frame of coordinates from the bad-pixel detector is recorded.
- Publishes the entry count (`bad_point_num`) to the bad-pixel checker, and only at frame boundaries, so the checker never scans a half-written table.

## Interface
Parameters:
- WIDTH_BITS, 10, x coordinate width
- HEIGHT_BITS, 10, y coordinate width
- BAD_POINT_NUM, 128, LUT depth; usable capacity is BAD_POINT_NUM-1 entries
- BAD_POINT_BIT, 7, LUT address and count width

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  pixel clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  frame marker, level; the boundary is its rising edge
- man_start  in  1  pulse: begin manual load
- man_valid  in  1  manual entry valid
- man_ready  out  1  manual entry accepted when valid&&ready
- man_x  in  WIDTH_BITS  manual x
- man_y  in  HEIGHT_BITS  manual y
- man_done  in  1  pulse: manual load complete
- cap_req  in  1  pulse: capture next full frame of detections
- det_valid  in  1  detector hit, no backpressure
- det_x  in  WIDTH_BITS  hit x
- det_y  in  HEIGHT_BITS  hit y
- wen_lut  out  1  LUT write enable
- waddr_lut  out  BAD_POINT_BIT  LUT write address
- wdata_lut  out  32  {16'(y), 16'(x)}, zero-extended
- bad_point_num  out  BAD_POINT_BIT  published entry count for the checker
- busy  out  1  state != IDLE
- order_err  out  1  sticky: manual entry not strictly ascending
- det_overflow  out  1  sticky: capture hit dropped because table full

## Operation
- Frame edge: `fs_prev` register, reset value 1. `fs_rise = frame_start && !fs_prev`.
- `wr_cnt` (BAD_POINT_BIT wide) is the next write address. Capacity is reached at `wr_cnt == BAD_POINT_NUM-1`.
- States: IDLE, MAN_LOAD, CAP_ARM, CAP_RUN, COMMIT_WAIT.
  - IDLE:
    - `man_start` → MAN_LOAD; `wr_cnt=0`; `bad_point_num=0` (checker disabled); clear `order_err`.
    - Otherwise `cap_req` → CAP_ARM; `bad_point_num=0`; clear `det_overflow`.
    - If both arrive together, `man_start` wins.
  - MAN_LOAD:
    - `man_ready = (wr_cnt < BAD_POINT_NUM-1)`.
    - On each accept, write at `wr_cnt` and increment `wr_cnt`.
    - An entry whose {y,x} is not greater than the previous accepted entry is accepted (handshake completes) but not written; `order_err` is set.
    - `man_done` → COMMIT_WAIT. Entries in the same cycle as `man_done` are ignored.
  - CAP_ARM: `fs_rise` → CAP_RUN; `wr_cnt=0`.
  - CAP_RUN:
    - Each `det_valid` writes at `wr_cnt` while below capacity. Otherwise the hit is dropped and `det_overflow` is set.
    - `fs_rise` → IDLE with `bad_point_num=wr_cnt`. A `det_valid` in that cycle is dropped and not flagged.
  - COMMIT_WAIT: `fs_rise` → IDLE with `bad_point_num=wr_cnt`.
- `man_start`, `cap_req`, `man_valid`, `det_valid` and `man_done` are ignored in states where they are not listed.
- `man_ready` = 0 outside MAN_LOAD.
- Count arithmetic never wraps; the capacity check precedes the increment.

## Timing
- Reset values:
  - state IDLE
  - `wen_lut`, `waddr_lut`, `wdata_lut`, `wr_cnt` = 0
  - `bad_point_num` = 0
  - `busy`, `order_err`, `det_overflow`, `man_ready` = 0
- Write latency: `wen_lut`, `waddr_lut` and `wdata_lut` are registered, asserted the cycle after the accept for exactly one cycle. Back-to-back accepts give back-to-back writes.
- Commit: `bad_point_num` updates on the clock edge after the cycle with `fs_rise`. This is the same cycle the checker resets its read address. The final write may land in that same cycle.
- `bad_point_num` drops to 0 on the edge after `man_start` or `cap_req` is taken.
- Reset mid-load or mid-capture: immediate return to IDLE with count 0. LUT contents are left stale and unreferenced.

## Configuration
- `BADPT_ORDER_CHECK_EN` defined: manual ascending-order check is active as described above.
- Not defined: all accepted manual entries are written; `order_err` is tied to 0; the previous-coordinate register is removed.

## Structure
- Package `badpt_pkg`:
  - state enum
  - `BADPT_CAP = BAD_POINT_NUM-1` derivation
  - `pack_coord(y,x)` function producing the 32-bit word
- Sub-module `badpt_edge_det`: rising-edge detector with reset-high history register. Reused for `frame_start`.

## Test plan
- Reset with `frame_start` held high → no `fs_rise`; all outputs 0; `bad_point_num` stays 0.
- Manual load of (y,x) = (5,3), (5,9), (20,1), then `man_done`, then a frame edge → writes at addresses 0..2 with wdata 0x00050003, 0x00050009, 0x00140001; `bad_point_num` = 3 one cycle after the edge.
- Manual (5,9) followed by (5,3) → second entry handshakes but is not written; `order_err` = 1; committed count = 1. Macro undefined → count = 2, `order_err` = 0.
- `cap_req`, then frame edge, then 130 consecutive `det_valid` hits, then frame edge → 127 writes; `det_overflow` = 1; `bad_point_num` = 127.
- `man_start` and `cap_req` in the same cycle → MAN_LOAD entered; `cap_req` ignored; `det_valid` during MAN_LOAD produces no write.
- `rst_n` deasserted mid-CAP_RUN after 10 hits → outputs at reset values; after release, state is IDLE and `bad_point_num` = 0.
